// File: rtl/display_timings_if.sv
// display_timings_if: video timing bundle produced by display_timings.
//   sx, sy   : current horizontal / vertical position (CORDW bits, unsigned)
//   hsync    : horizontal sync at the configured polarity
//   vsync    : vertical sync at the configured polarity
//   de       : data enable, high only inside the active picture
//   ctrl     : {vsync, hsync}, feeds the blue-channel encoder ctrl_in
//   frame    : one-cycle pulse at (0,0)
//   line     : one-cycle pulse at sx == 0 on every line
// master = timing generator, slave = consumer.
interface display_timings_if #(
    parameter int CORDW = 16
);
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [1:0]       ctrl;
    logic             frame;
    logic             line;

    modport master (output sx, sy, hsync, vsync, de, ctrl, frame, line);
    modport slave  (input  sx, sy, hsync, vsync, de, ctrl, frame, line);
endinterface

// File: rtl/display_timings.sv
// display_timings: raster timing generator for a single pixel-clock domain.
//   clk_pix : pixel clock
//   rst_pix : synchronous, active-high reset
//   vid     : display_timings_if master port (sx, sy, syncs, de, ctrl, frame, line)
// Each line runs active -> front porch -> sync -> back porch; the vertical axis
// uses the same order. Outputs are registered and all decoded from the same
// next-position value, so they change together with no skew.
module display_timings #(
    parameter int   CORDW  = 16,
    parameter int   H_RES  = 640,
    parameter int   H_FP   = 16,
    parameter int   H_SYNC = 96,
    parameter int   H_BP   = 48,
    parameter int   V_RES  = 480,
    parameter int   V_FP   = 10,
    parameter int   V_SYNC = 2,
    parameter int   V_BP   = 33,
    parameter logic H_POL  = 1'b0,
    parameter logic V_POL  = 1'b0
) (
    input  logic                clk_pix,
    input  logic                rst_pix,
    display_timings_if.master   vid
);

    localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
    localparam logic [CORDW-1:0] H_SSTART = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] H_SEND   = CORDW'(H_RES + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] H_TOTAL  = CORDW'(H_RES + H_FP + H_SYNC + H_BP);
    localparam logic [CORDW-1:0] H_LAST   = H_TOTAL - CORDW'(1);

    localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
    localparam logic [CORDW-1:0] V_SSTART = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] V_SEND   = CORDW'(V_RES + V_FP + V_SYNC);
    localparam logic [CORDW-1:0] V_TOTAL  = CORDW'(V_RES + V_FP + V_SYNC + V_BP);
    localparam logic [CORDW-1:0] V_LAST   = V_TOTAL - CORDW'(1);

    logic [CORDW-1:0] sx_q, sx_d;
    logic [CORDW-1:0] sy_q, sy_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             frame_q, frame_d;
    logic             line_q, line_d;

    // Decode is taken from the next position so the registered flags line up
    // with the registered coordinates in the same cycle.
    always_comb begin
        sx_d = sx_q + CORDW'(1);
        sy_d = sy_q;
        if (sx_q == H_LAST) begin
            sx_d = '0;
            sy_d = (sy_q == V_LAST) ? '0 : sy_q + CORDW'(1);
        end

        de_d    = (sx_d < H_ACT) && (sy_d < V_ACT);
        hsync_d = ((sx_d >= H_SSTART) && (sx_d < H_SEND)) ? H_POL : ~H_POL;
        vsync_d = ((sy_d >= V_SSTART) && (sy_d < V_SEND)) ? V_POL : ~V_POL;
        frame_d = (sx_d == '0) && (sy_d == '0);
        line_d  = (sx_d == '0);
    end

    // Reset parks the raster on the last pixel of the frame so that the first
    // clock after release lands on (0,0); any sync in progress is dropped.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            sx_q    <= H_LAST;
            sy_q    <= V_LAST;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
            frame_q <= 1'b0;
            line_q  <= 1'b0;
        end else begin
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            frame_q <= frame_d;
            line_q  <= line_d;
        end
    end

    assign vid.sx    = sx_q;
    assign vid.sy    = sy_q;
    assign vid.hsync = hsync_q;
    assign vid.vsync = vsync_q;
    assign vid.de    = de_q;
    assign vid.ctrl  = {vsync_q, hsync_q};
    assign vid.frame = frame_q;
    assign vid.line  = line_q;

endmodule

// File: tb/tb_display_timings.sv
module tb_display_timings;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    display_timings_if #(.CORDW(16)) if_a ();
    display_timings_if #(.CORDW(16)) if_b ();
    display_timings_if #(.CORDW(16)) if_c ();

    // A: all defaults
    display_timings #(.CORDW(16)) dut_a (.clk_pix(clk), .rst_pix(rst_a), .vid(if_a));

    // B: default horizontal, short vertical, active-high syncs
    display_timings #(.CORDW(16), .V_RES(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
                      .H_POL(1'b1), .V_POL(1'b1))
        dut_b (.clk_pix(clk), .rst_pix(rst_b), .vid(if_b));

    // C: tiny raster for exhaustive checking
    display_timings #(.CORDW(16), .H_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                      .V_RES(2), .V_FP(1), .V_SYNC(1), .V_BP(1))
        dut_c (.clk_pix(clk), .rst_pix(rst_c), .vid(if_c));

    typedef struct packed {
        logic [15:0] sx;
        logic [15:0] sy;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fr;
        logic        ln;
        logic [1:0]  ctrl;
    } vout_t;

    int total = 0;
    int bad   = 0;

    // Pixel index since reset release; -1 while in reset.
    int na = -1;
    int nb = -1;
    int nc = -1;
    always @(posedge clk) begin
        na <= rst_a ? -1 : na + 1;
        nb <= rst_b ? -1 : nb + 1;
        nc <= rst_c ? -1 : nc + 1;
    end

    // Reference: position is pixel index modulo the raster size.
    function automatic vout_t model(int n, int hr, int hf, int hsw, int hb,
                                    int vr, int vf, int vsw, int vb, bit hp, bit vp);
        vout_t o;
        int ht = hr + hf + hsw + hb;
        int vt = vr + vf + vsw + vb;
        int x, y;
        if (n < 0) begin
            o.sx = 16'(ht - 1);
            o.sy = 16'(vt - 1);
            o.de = 1'b0;
            o.fr = 1'b0;
            o.ln = 1'b0;
            o.hs = ~hp;
            o.vs = ~vp;
        end else begin
            x = n % ht;
            y = (n / ht) % vt;
            o.sx = 16'(x);
            o.sy = 16'(y);
            o.de = (x < hr) && (y < vr);
            o.hs = ((x >= hr + hf) && (x < hr + hf + hsw)) ? hp : ~hp;
            o.vs = ((y >= vr + vf) && (y < vr + vf + vsw)) ? vp : ~vp;
            o.fr = (x == 0) && (y == 0);
            o.ln = (x == 0);
        end
        o.ctrl = {o.vs, o.hs};
        return o;
    endfunction

    function automatic vout_t exp_a();
        return model(na, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    endfunction
    function automatic vout_t exp_b();
        return model(nb, 640, 16, 96, 48, 6, 2, 2, 2, 1'b1, 1'b1);
    endfunction
    function automatic vout_t exp_c();
        return model(nc, 4, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0);
    endfunction

    function automatic vout_t obs_a();
        return {if_a.sx, if_a.sy, if_a.hsync, if_a.vsync, if_a.de, if_a.frame, if_a.line, if_a.ctrl};
    endfunction
    function automatic vout_t obs_b();
        return {if_b.sx, if_b.sy, if_b.hsync, if_b.vsync, if_b.de, if_b.frame, if_b.line, if_b.ctrl};
    endfunction
    function automatic vout_t obs_c();
        return {if_c.sx, if_c.sy, if_c.hsync, if_c.vsync, if_c.de, if_c.frame, if_c.line, if_c.ctrl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        repeat (3) begin
            tick();
            total++;
            if (obs_a() !== exp_a()) begin
                bad++;
                $display("FAIL reset_model_a got=%h want=%h", obs_a(), exp_a());
            end
        end
        total++;
        if (if_a.sx !== 16'd799 || if_a.sy !== 16'd524) begin
            bad++;
            $display("FAIL reset_pos got=(%0d,%0d) want=(799,524)", if_a.sx, if_a.sy);
        end
        total++;
        if ({if_a.hsync, if_a.vsync, if_a.de, if_a.frame, if_a.line} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=11000",
                     {if_a.hsync, if_a.vsync, if_a.de, if_a.frame, if_a.line});
        end
        rst_a = 1'b0;
        tick();
        total++;
        if ({if_a.sx, if_a.sy} !== 32'd0 ||
            {if_a.de, if_a.frame, if_a.line, if_a.hsync, if_a.vsync} !== 5'b11111) begin
            bad++;
            $display("FAIL release_first got=(%0d,%0d) flags=%b want=(0,0) flags=11111",
                     if_a.sx, if_a.sy, {if_a.de, if_a.frame, if_a.line, if_a.hsync, if_a.vsync});
        end
    endtask

    task automatic test_line();
        int de_cnt = 0;
        int hs_lo = 0;
        int hs_first = -1;
        int hs_last = -1;
        for (int c = 0; c < 800; c++) begin
            total++;
            if (obs_a() !== exp_a()) begin
                bad++;
                $display("FAIL line_model n=%0d got=%h want=%h", na, obs_a(), exp_a());
            end
            if (if_a.de === 1'b1) de_cnt++;
            if (if_a.hsync === 1'b0) begin
                hs_lo++;
                if (hs_first < 0) hs_first = c;
                hs_last = c;
            end
            tick();
        end
        total++;
        if (if_a.line !== 1'b1 || if_a.sx !== 16'd0 || if_a.sy !== 16'd1) begin
            bad++;
            $display("FAIL line_again got line=%b (%0d,%0d) want line=1 (0,1)", if_a.line, if_a.sx, if_a.sy);
        end
        total++;
        if (de_cnt !== 640) begin
            bad++;
            $display("FAIL de_count got=%0d want=640", de_cnt);
        end
        total++;
        if (hs_lo !== 96 || hs_first !== 656 || hs_last !== 751) begin
            bad++;
            $display("FAIL hsync_window got=%0d [%0d..%0d] want=96 [656..751]", hs_lo, hs_first, hs_last);
        end
        for (int c = 0; c < 800; c++) begin
            total++;
            if (obs_a() !== exp_a()) begin
                bad++;
                $display("FAIL line2_model n=%0d got=%h want=%h", na, obs_a(), exp_a());
            end
            tick();
        end
    endtask

    task automatic test_polarity_frame();
        int fr_cnt = 0;
        int vs_hi = 0;
        int hs_hi = 0;
        int de_cnt = 0;
        rst_b = 1'b1;
        tick();
        tick();
        rst_b = 1'b0;
        tick();
        for (int c = 0; c < 2 * 9600; c++) begin
            total++;
            if (obs_b() !== exp_b()) begin
                bad++;
                $display("FAIL pol_model n=%0d got=%h want=%h", nb, obs_b(), exp_b());
            end
            if (if_b.frame === 1'b1) fr_cnt++;
            if (if_b.vsync === 1'b1) vs_hi++;
            if (if_b.hsync === 1'b1) hs_hi++;
            if (if_b.de === 1'b1) de_cnt++;
            if (c == 9599) begin
                total++;
                if (if_b.sx !== 16'd799 || if_b.sy !== 16'd11) begin
                    bad++;
                    $display("FAIL frame_end got=(%0d,%0d) want=(799,11)", if_b.sx, if_b.sy);
                end
            end
            if (c == 9600) begin
                total++;
                if (if_b.sx !== 16'd0 || if_b.sy !== 16'd0 || if_b.frame !== 1'b1) begin
                    bad++;
                    $display("FAIL frame_wrap got=(%0d,%0d) frame=%b want=(0,0) frame=1",
                             if_b.sx, if_b.sy, if_b.frame);
                end
            end
            tick();
        end
        total++;
        if (fr_cnt !== 2) begin
            bad++;
            $display("FAIL frame_count got=%0d want=2", fr_cnt);
        end
        total++;
        if (vs_hi !== 2 * 2 * 800 || hs_hi !== 2 * 12 * 96) begin
            bad++;
            $display("FAIL sync_counts got vs=%0d hs=%0d want vs=3200 hs=2304", vs_hi, hs_hi);
        end
        total++;
        if (de_cnt !== 2 * 6 * 640) begin
            bad++;
            $display("FAIL pol_de_count got=%0d want=7680", de_cnt);
        end
    endtask

    task automatic test_reset_mid_sync();
        int guard = 0;
        int hold;
        while ((nb % 9600) != 7100 && guard < 9600) begin
            total++;
            if (obs_b() !== exp_b()) begin
                bad++;
                $display("FAIL seek_model n=%0d got=%h want=%h", nb, obs_b(), exp_b());
            end
            tick();
            guard++;
        end
        total++;
        if ((nb % 9600) != 7100) begin
            bad++;
            $display("FAIL seek_timeout got n=%0d want=7100", nb);
        end
        total++;
        if (if_b.hsync !== 1'b1 || if_b.vsync !== 1'b1 || if_b.sx !== 16'd700 || if_b.sy !== 16'd8) begin
            bad++;
            $display("FAIL presync got hs=%b vs=%b (%0d,%0d) want hs=1 vs=1 (700,8)",
                     if_b.hsync, if_b.vsync, if_b.sx, if_b.sy);
        end
        rst_b = 1'b1;
        tick();
        total++;
        if (if_b.hsync !== 1'b0 || if_b.vsync !== 1'b0 || if_b.sx !== 16'd799 ||
            if_b.sy !== 16'd11 || if_b.de !== 1'b0 || if_b.ctrl !== 2'b00) begin
            bad++;
            $display("FAIL midreset got hs=%b vs=%b ctrl=%b (%0d,%0d) de=%b want 0 0 00 (799,11) 0",
                     if_b.hsync, if_b.vsync, if_b.ctrl, if_b.sx, if_b.sy, if_b.de);
        end
        hold = $urandom_range(0, 3);
        repeat (hold) begin
            tick();
            total++;
            if (obs_b() !== exp_b()) begin
                bad++;
                $display("FAIL reset_hold got=%h want=%h", obs_b(), exp_b());
            end
        end
        rst_b = 1'b0;
        tick();
        total++;
        if (if_b.sx !== 16'd0 || if_b.sy !== 16'd0 || if_b.frame !== 1'b1 ||
            if_b.line !== 1'b1 || if_b.de !== 1'b1) begin
            bad++;
            $display("FAIL midreset_release got=(%0d,%0d) fr=%b ln=%b de=%b want (0,0) 1 1 1",
                     if_b.sx, if_b.sy, if_b.frame, if_b.line, if_b.de);
        end
    endtask

    task automatic test_small_random();
        int fr_cnt = 0;
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        tick();
        for (int c = 0; c < 3 * 35; c++) begin
            total++;
            if (obs_c() !== exp_c()) begin
                bad++;
                $display("FAIL small_model n=%0d got=%h want=%h", nc, obs_c(), exp_c());
            end
            if (if_c.frame === 1'b1) fr_cnt++;
            tick();
        end
        total++;
        if (fr_cnt !== 3) begin
            bad++;
            $display("FAIL small_frames got=%0d want=3", fr_cnt);
        end
        for (int c = 0; c < 400; c++) begin
            rst_c = ($urandom_range(0, 15) == 0);
            tick();
            total++;
            if (obs_c() !== exp_c()) begin
                bad++;
                $display("FAIL small_rand n=%0d got=%h want=%h", nc, obs_c(), exp_c());
            end
        end
        rst_c = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line();
        test_polarity_frame();
        test_reset_mid_sync();
        test_small_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
